regfile_seq: RTL and testbench

- Micro-op sequencer that sits directly upstream of the 4x4 register file.
- Accepts one instruction per valid/ready handshake and drives the register file ports: Aaddr, Baddr, WR, Daddr, Ddata.
- Computes the result in an internal ALU from the returned Adata/Bdata and writes it back.
- Keeps Z/C flags and a retired-instruction counter for the debug display.

---
 rtl/regfile_seq.sv | 112 +++++++++++
 tb/tb_regfile_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_seq.sv
// Three-state micro-op sequencer in front of a 4x4 register file: it accepts an
// instruction, reads its operands, runs the ALU and writes the result back.
module regfile_seq #(
    parameter int DW = 4,
    parameter int AW = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [3*AW+2:0]   instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [DW-1:0]     Adata,
    input  logic [DW-1:0]     Bdata,
    output logic [AW-1:0]     Aaddr,
    output logic [AW-1:0]     Baddr,
    output logic              WR,
    output logic [AW-1:0]     Daddr,
    output logic [DW-1:0]     Ddata,
    output logic              done,
    output logic              Zflag,
    output logic              Cflag,
    output logic [7:0]        icount,
    output logic [1:0]        dbg_state
);

    // Handshake: an instruction transfers at the posedge where instr_valid and
    // instr_ready are both high; instr_ready is high only in IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state, next_state;

    logic [3*AW+2:0] ir;
    logic [DW-1:0]   result;
    logic [DW-1:0]   alu_res;
    logic            alu_c;
    logic [DW:0]     sum;
    logic [DW:0]     diff;
    logic [2:0]      op;

    assign op = ir[3*AW +: 3];

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (instr_valid) next_state = EXEC;
            EXEC:    next_state = WB;
            WB:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == IDLE);
        WR          = (state == WB) && !RST;
        done        = (state == WB);
        Aaddr       = ir[AW +: AW];
        Baddr       = ir[0 +: AW];
        Daddr       = ir[2*AW +: AW];
        Ddata       = result;
        dbg_state   = state;
    end

    // Extra top bit of sum/diff carries the ADD carry and the SUB borrow.
    always_comb begin
        sum     = {1'b0, Adata} + {1'b0, Bdata};
        diff    = {1'b0, Adata} - {1'b0, Bdata};
        alu_res = '0;
        alu_c   = 1'b0;
        case (op)
            3'b000: alu_res = ir[2*AW-1:0];
            3'b001: alu_res = Adata;
            3'b010: begin alu_res = sum[DW-1:0];  alu_c = sum[DW];  end
            3'b011: begin alu_res = diff[DW-1:0]; alu_c = diff[DW]; end
            3'b100: alu_res = Adata & Bdata;
            3'b101: alu_res = Adata | Bdata;
            3'b110: alu_res = Adata ^ Bdata;
            3'b111: alu_res = ~Adata;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ir     <= '0;
            result <= '0;
            Zflag  <= 1'b0;
            Cflag  <= 1'b0;
            icount <= 8'd0;
        end else begin
            case (state)
                IDLE: if (instr_valid) ir <= instr;
                EXEC: begin
                    result <= alu_res;
                    Zflag  <= (alu_res == '0);
                    Cflag  <= alu_c;
                end
                WB:   icount <= icount + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq: a behavioural register file on the write/read ports,
// a reference model feeding an expected-writeback queue, and per-cycle timing checks.
module tb_regfile_seq;

    logic       CLK = 1'b0;
    logic       RST;
    logic [8:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] Adata, Bdata;
    logic [1:0] Aaddr, Baddr, Daddr;
    logic       WR, done, Zflag, Cflag;
    logic [3:0] Ddata;
    logic [7:0] icount;
    logic [1:0] dbg_state;

    regfile_seq #(.DW(4), .AW(2)) dut (
        .CLK(CLK), .RST(RST), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .Adata(Adata), .Bdata(Bdata),
        .Aaddr(Aaddr), .Baddr(Baddr), .WR(WR), .Daddr(Daddr), .Ddata(Ddata),
        .done(done), .Zflag(Zflag), .Cflag(Cflag), .icount(icount),
        .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    // Register file seen by the sequencer
    logic [3:0] rf [4];
    assign Adata = rf[Aaddr];
    assign Bdata = rf[Baddr];
    always @(posedge CLK) if (WR) rf[Daddr] <= Ddata;

    logic [3:0] ref_rf [4];
    logic [7:0] exp_q [$];
    logic [7:0] exp_icnt;
    logic       suppress;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model one instruction; returns packed {D, result, Z, C}
    task automatic model(input logic [8:0] ins, output logic [7:0] e);
        logic [3:0] av, bv, r;
        logic       c;
        int         s;
        av = ref_rf[ins[3:2]];
        bv = ref_rf[ins[1:0]];
        c  = 1'b0;
        case (ins[8:6])
            3'd0: r = ins[3:0];
            3'd1: r = av;
            3'd2: begin s = av + bv; r = s[3:0]; c = (s >= 16); end
            3'd3: begin r = av - bv; c = (av < bv); end
            3'd4: r = av & bv;
            3'd5: r = av | bv;
            3'd6: r = av ^ bv;
            default: r = ~av;
        endcase
        ref_rf[ins[5:4]] = r;
        e = {ins[5:4], r, (r == 4'd0), c};
    endtask

    always @(negedge CLK) begin
        logic [7:0] e;
        if (done && !suppress) begin
            if (exp_q.size() == 0) check("unexpected_done", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("wb_daddr", Daddr, e[7:6]);
                check("wb_ddata", Ddata, e[5:2]);
                check("zflag", Zflag, e[1]);
                check("cflag", Cflag, e[0]);
            end
        end
    end

    task automatic issue(input logic [8:0] ins, input bit keep);
        logic [7:0] e;
        int t;
        @(negedge CLK);
        t = 0;
        while (!instr_ready && t < 8) begin @(negedge CLK); t++; end
        check("ready_wait", instr_ready, 1);
        instr       = ins;
        instr_valid = 1'b1;
        model(ins, e);
        exp_q.push_back(e);
        exp_icnt++;
        @(negedge CLK);
        if (!keep) instr_valid = 1'b0;
        check("exec_ready", instr_ready, 0);
        check("exec_wr", WR, 0);
        check("exec_done", done, 0);
        @(negedge CLK);
        check("wb_ready", instr_ready, 0);
        check("wb_wr", WR, 1);
        check("wb_done", done, 1);
    endtask

    task automatic check_regs();
        for (int i = 0; i < 4; i++) check($sformatf("rf_r%0d", i), rf[i], ref_rf[i]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin rf[i] = 4'd0; ref_rf[i] = 4'd0; end
        exp_icnt    = 8'd0;
        suppress    = 1'b0;
        RST         = 1'b1;
        instr       = 9'd0;
        instr_valid = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check("rst_ready", instr_ready, 1);
        check("rst_wr", WR, 0);
        check("rst_done", done, 0);
        check("rst_aaddr", Aaddr, 0);
        check("rst_baddr", Baddr, 0);
        check("rst_daddr", Daddr, 0);
        check("rst_ddata", Ddata, 0);
        check("rst_z", Zflag, 0);
        check("rst_c", Cflag, 0);
        check("rst_icount", icount, 0);

        // LDI R1,9
        issue(9'b000_01_10_01, 0);
        @(negedge CLK);
        check("ldi_r1", rf[1], 4'h9);
        check("icount_1", icount, 8'd1);

        // LDI R2,8 ; ADD R3,R1,R2 -> 1 with carry
        issue(9'b000_10_10_00, 0);
        issue(9'b010_11_01_10, 0);
        @(negedge CLK);
        check("add_r3", rf[3], 4'h1);
        check("add_c", Cflag, 1);
        check("add_z", Zflag, 0);

        // R1=3, R2=5: SUB R0,R1,R2 then SUB R0,R2,R2
        issue(9'b000_01_00_11, 0);
        issue(9'b000_10_01_01, 0);
        issue(9'b011_00_01_10, 0);
        @(negedge CLK);
        check("sub_r0", rf[0], 4'hE);
        check("sub_c", Cflag, 1);
        issue(9'b011_00_10_10, 0);
        @(negedge CLK);
        check("sub_self_r0", rf[0], 4'h0);
        check("sub_self_z", Zflag, 1);
        check("sub_self_c", Cflag, 0);
        check_regs();

        // Stream with instr_valid held high throughout
        issue(9'b000_11_10_10, 1);
        issue(9'b110_10_11_01, 1);
        issue(9'b111_01_10_00, 1);
        issue(9'b101_00_01_11, 0);
        @(negedge CLK);
        check("stream_icount", icount, exp_icnt);
        check_regs();

        for (int k = 0; k < 24; k++) issue(9'($urandom_range(0, 511)), ($urandom_range(0, 1) == 1));
        instr_valid = 1'b0;
        @(negedge CLK);
        check("rand_icount", icount, exp_icnt);
        check_regs();

        // Reset during WB of LDI R2,0xF must drop the write
        issue(9'b000_10_10_00, 0);
        @(negedge CLK);
        check("pre_r2", rf[2], 4'h8);
        instr       = 9'b000_10_11_11;
        instr_valid = 1'b1;
        @(negedge CLK);
        instr_valid = 1'b0;
        @(negedge CLK);
        suppress = 1'b1;
        RST      = 1'b1;
        #1;
        check("rst_wb_wr", WR, 0);
        @(negedge CLK);
        RST      = 1'b0;
        suppress = 1'b0;
        check("rst_wb_r2", rf[2], 4'h8);
        check("rst_wb_icount", icount, 8'd0);
        check("rst_wb_state", dbg_state, 0);
        check("rst_wb_ready", instr_ready, 1);
        exp_icnt = 8'd0;

        // 256 LDI R0,0: icount wraps, Z set each time
        for (int k = 0; k < 256; k++) issue(9'b000_00_00_00, 0);
        @(negedge CLK);
        check("wrap_icount", icount, 8'd0);
        check("wrap_z", Zflag, 1);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
